pht_local: RTL and testbench

Second-level pattern history table for the local two-level branch predictor. Consumes the per-branch history produced by the branch history table and returns a taken/not-taken prediction to fetch. Holds one 2-bit saturating counter per {PC index, history} pair. Counters are trained through a registered update pipeline with forwarding, and the block exposes lookup and mispredict performance counters.

---
 rtl/pht_local.sv | 92 +++++++++
 tb/tb_pht_local.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_local.sv
// rtl/pht_local.sv - local-predictor pattern history table with a forwarding update stage
// 2-bit saturating counters indexed by {pc index, local history}, plus saturating perf counters.
module pht_local #(
  parameter int s_index   = 4,
  parameter int depth     = 4,
  parameter int cnt_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [s_index-1:0]   pred_idx,
  input  logic [depth-1:0]     pred_hist,
  output logic                 pred_taken,
  input  logic                 upd_valid,
  input  logic [s_index-1:0]   upd_idx,
  input  logic [depth-1:0]     upd_hist,
  input  logic                 upd_taken,
  input  logic                 upd_mispredict,
  output logic [cnt_width-1:0] lookups,
  output logic [cnt_width-1:0] mispredicts
);

  localparam int AW      = s_index + depth;
  localparam int ENTRIES = 1 << AW;
  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  logic [1:0]           tbl_q [ENTRIES];
  logic                 p_valid_q, p_valid_d;
  logic [AW-1:0]        p_addr_q, p_addr_d;
  logic                 p_taken_q, p_taken_d;
  logic [cnt_width-1:0] lookups_q, lookups_d;
  logic [cnt_width-1:0] mispredicts_q, mispredicts_d;

  logic [1:0]    cur_cnt;
  logic [1:0]    new_cnt;
  logic [AW-1:0] lk_addr;

  // The prior pending write has already landed when this stage reads the
  // table, so back-to-back updates to one entry accumulate.
  always_comb begin
    cur_cnt = tbl_q[p_addr_q];
    new_cnt = cur_cnt;
    if (p_taken_q) begin
      if (cur_cnt != 2'b11) new_cnt = cur_cnt + 2'd1;
    end else begin
      if (cur_cnt != 2'b00) new_cnt = cur_cnt - 2'd1;
    end
  end

  always_comb begin
    lk_addr = {pred_idx, pred_hist};
    pred_taken = tbl_q[lk_addr][1];
    if (p_valid_q && (p_addr_q == lk_addr)) pred_taken = new_cnt[1];
  end

  always_comb begin
    p_valid_d     = upd_valid;
    p_addr_d      = p_addr_q;
    p_taken_d     = p_taken_q;
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (upd_valid) begin
      p_addr_d  = {upd_idx, upd_hist};
      p_taken_d = upd_taken;
    end
    if (pred_valid && (lookups_q != {cnt_width{1'b1}})) lookups_d = lookups_q + CNT_ONE;
    if (upd_valid && upd_mispredict && (mispredicts_q != {cnt_width{1'b1}}))
      mispredicts_d = mispredicts_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= 2'b10;
      p_valid_q     <= 1'b0;
      p_addr_q      <= '0;
      p_taken_q     <= 1'b0;
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (p_valid_q) tbl_q[p_addr_q] <= new_cnt;
      p_valid_q     <= p_valid_d;
      p_addr_q      <= p_addr_d;
      p_taken_q     <= p_taken_d;
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign lookups     = lookups_q;
  assign mispredicts = mispredicts_q;

endmodule

// File: tb/tb_pht_local.sv
// tb/tb_pht_local.sv - directed self-checking bench for pht_local
// Narrow perf counters so saturation is reachable in a short run.
module tb_pht_local;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid;
  logic [3:0] pred_idx;
  logic [3:0] pred_hist;
  logic       pred_taken;
  logic       upd_valid;
  logic [3:0] upd_idx;
  logic [3:0] upd_hist;
  logic       upd_taken;
  logic       upd_mispredict;
  logic [3:0] lookups;
  logic [3:0] mispredicts;

  int total = 0;
  int bad   = 0;

  pht_local #(.s_index(4), .depth(4), .cnt_width(4)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_idx(pred_idx), .pred_hist(pred_hist),
    .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .lookups(lookups), .mispredicts(mispredicts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (lookups !== 4'd0) begin
      $display("FAIL reset_lookups actual=%0d expected=0", lookups); bad++;
    end
    total++;
    if (mispredicts !== 4'd0) begin
      $display("FAIL reset_mispredicts actual=%0d expected=0", mispredicts); bad++;
    end
    for (int i = 0; i < 16; i += 5) begin
      pred_idx = i[3:0]; pred_hist = 4'(15 - i);
      #1;
      total++;
      if (pred_taken !== 1'b1) begin
        $display("FAIL reset_pred_%0d actual=%0b expected=1", i, pred_taken); bad++;
      end
    end
    pred_valid = 1'b1; pred_idx = 4'd3; pred_hist = 4'b0101;
    #1;
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL reset_pred_3_5 actual=%0b expected=1", pred_taken); bad++;
    end
    tick();
    pred_valid = 1'b0;
    total++;
    if (lookups !== 4'd1) begin
      $display("FAIL lookup_count_one actual=%0d expected=1", lookups); bad++;
    end
  endtask

  task automatic test_train();
    upd_idx = 4'd2; upd_hist = 4'hF; pred_idx = 4'd2; pred_hist = 4'hF;
    upd_taken = 1'b0; upd_valid = 1'b1;
    tick();
    tick();
    upd_valid = 1'b0;
    tick();
    tick();
    total++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL train_nt_nt actual=%0b expected=0", pred_taken); bad++;
    end
    upd_taken = 1'b1; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    total++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL train_t_from_00 actual=%0b expected=0", pred_taken); bad++;
    end
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL train_t_from_01 actual=%0b expected=1", pred_taken); bad++;
    end
  endtask

  task automatic test_saturate();
    upd_idx = 4'd5; upd_hist = 4'd3; pred_idx = 4'd5; pred_hist = 4'd3;
    upd_taken = 1'b1; upd_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL sat_forward_nt actual=%0b expected=1", pred_taken); bad++;
    end
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL sat_table_10 actual=%0b expected=1", pred_taken); bad++;
    end
    upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    total++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL sat_forward_01 actual=%0b expected=0", pred_taken); bad++;
    end
    tick();
    total++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL sat_table_01 actual=%0b expected=0", pred_taken); bad++;
    end
  endtask

  task automatic test_back_to_back();
    upd_idx = 4'd4; upd_hist = 4'd6; pred_idx = 4'd4; pred_hist = 4'd6;
    upd_taken = 1'b0; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    upd_taken = 1'b1; upd_valid = 1'b1;
    tick();
    tick();
    upd_valid = 1'b0;
    tick();
    upd_taken = 1'b0; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL b2b_accumulate actual=%0b expected=1", pred_taken); bad++;
    end
  endtask

  task automatic test_forward();
    upd_idx = 4'd7; upd_hist = 4'd9; pred_idx = 4'd7; pred_hist = 4'd9;
    upd_taken = 1'b0; upd_valid = 1'b1;
    #1;
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL fwd_same_cycle actual=%0b expected=1", pred_taken); bad++;
    end
    tick();
    upd_valid = 1'b0;
    #1;
    total++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL fwd_pending actual=%0b expected=0", pred_taken); bad++;
    end
    pred_hist = 4'd8;
    #1;
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL fwd_other_hist actual=%0b expected=1", pred_taken); bad++;
    end
    pred_hist = 4'd9;
    tick();
    total++;
    if (pred_taken !== 1'b0) begin
      $display("FAIL fwd_written actual=%0b expected=0", pred_taken); bad++;
    end
  endtask

  task automatic test_counters();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    upd_idx = 4'hF; upd_hist = 4'hF; upd_taken = 1'b1;
    upd_mispredict = 1'b1; upd_valid = 1'b0;
    tick();
    total++;
    if (mispredicts !== 4'd0) begin
      $display("FAIL mis_needs_valid actual=%0d expected=0", mispredicts); bad++;
    end
    pred_valid = 1'b1; upd_valid = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (lookups !== 4'd14) begin
      $display("FAIL lookups_14 actual=%0d expected=14", lookups); bad++;
    end
    total++;
    if (mispredicts !== 4'd14) begin
      $display("FAIL mispredicts_14 actual=%0d expected=14", mispredicts); bad++;
    end
    for (int i = 0; i < 6; i++) tick();
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    total++;
    if (lookups !== 4'd15) begin
      $display("FAIL lookups_sat actual=%0d expected=15", lookups); bad++;
    end
    total++;
    if (mispredicts !== 4'd15) begin
      $display("FAIL mispredicts_sat actual=%0d expected=15", mispredicts); bad++;
    end
  endtask

  task automatic test_reset_mid();
    upd_idx = 4'd1; upd_hist = 4'd2; pred_idx = 4'd1; pred_hist = 4'd2;
    upd_taken = 1'b0; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL rstmid_pred actual=%0b expected=1", pred_taken); bad++;
    end
    tick();
    tick();
    total++;
    if (pred_taken !== 1'b1) begin
      $display("FAIL rstmid_no_write actual=%0b expected=1", pred_taken); bad++;
    end
    total++;
    if (lookups !== 4'd0 || mispredicts !== 4'd0) begin
      $display("FAIL rstmid_counters actual=%0d/%0d expected=0/0", lookups, mispredicts); bad++;
    end
  endtask

  initial begin
    rst = 1'b1; pred_valid = 1'b0; pred_idx = '0; pred_hist = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_hist = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    test_reset();
    test_train();
    test_saturate();
    test_back_to_back();
    test_forward();
    test_counters();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
